tnoc_vc_output_switch: RTL and testbench

- Parametrised per-output-port switch stage for next-generation tnoc routers.
- Generalises the fixed 5-port output block to PORTS inputs and CHANNELS virtual channels.
- Adds credit-based flow control towards the downstream buffer, replacing ready/valid back-pressure.
- Wormhole switching: one input port is locked per VC per packet; VCs are interleaved flit-by-flit on one output link.

---
 rtl/tnoc_pkg.sv | 15 +
 rtl/tnoc_round_robin_arbiter.sv | 48 ++++
 rtl/tnoc_vc_output_switch.sv | 224 ++++++++++++++++++++++
 tb/tb_tnoc_vc_output_switch.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnoc_pkg.sv
// Shared types and helpers for the tnoc router slice.
package tnoc_pkg;

    // Per-VC wormhole lock: free for a new packet head, or owned by one port.
    typedef enum logic {
        IDLE,
        LOCKED
    } tnoc_vc_lock_state;

    // Bits needed to hold a credit count in the range 0..credits.
    function automatic int unsigned credit_count_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/tnoc_round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer; the
// pointer moves one past the granted requester when i_advance is strobed.
module tnoc_round_robin_arbiter #(
    parameter int unsigned REQUESTS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REQUESTS-1:0] i_request,
    input  logic                i_advance,
    output logic [REQUESTS-1:0] o_grant
);

    localparam int unsigned PW = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;

    logic [PW-1:0] pointer;
    logic [PW-1:0] grant_index;
    logic          found;
    int unsigned   idx;

    // Scan requesters starting at the pointer, wrapping once; first hit wins.
    always_comb begin
        o_grant     = '0;
        grant_index = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < REQUESTS; i++) begin
            idx = i + 32'(pointer);
            if (idx >= REQUESTS) begin
                idx = idx - REQUESTS;
            end
            if (!found && i_request[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                grant_index  = PW'(idx);
            end
        end
    end

    // Pointer moves past the winner only when the caller confirms the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pointer <= '0;
        end else if (i_advance && found) begin
            pointer <= (grant_index == PW'(REQUESTS - 1)) ? '0 : grant_index + 1'b1;
        end
    end

endmodule

// File: rtl/tnoc_vc_output_switch.sv
// Per-output-port VC switch with wormhole locking and credit flow control.
// Build option: TNOC_VC_FIXED_PRIORITY_EN selects a fixed-priority VC
// select (VC0 highest) instead of round-robin.
module tnoc_vc_output_switch
    import tnoc_pkg::*;
#(
    parameter int unsigned PORTS      = 5,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned CREDITS    = 4
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [PORTS*CHANNELS-1:0]                        i_valid,
    input  logic [PORTS*CHANNELS-1:0]                        i_last,
    input  logic [PORTS*CHANNELS*FLIT_WIDTH-1:0]             i_flit,
    output logic [PORTS*CHANNELS-1:0]                        o_ready,
    output logic                                             o_valid,
    output logic [CHANNELS-1:0]                              o_vc,
    output logic                                             o_last,
    output logic [FLIT_WIDTH-1:0]                            o_flit,
    input  logic [CHANNELS-1:0]                              i_credit_return,
    output logic [CHANNELS*credit_count_width(CREDITS)-1:0]  o_credit_count
);

    localparam int unsigned CW  = credit_count_width(CREDITS);
    localparam int unsigned PIW = (PORTS > 1) ? $clog2(PORTS) : 1;

    tnoc_vc_lock_state                  lock_state      [CHANNELS];
    tnoc_vc_lock_state                  lock_state_next [CHANNELS];
    logic [PIW-1:0]                     lock_owner      [CHANNELS];
    logic [PIW-1:0]                     lock_owner_next [CHANNELS];
    logic [CW-1:0]                      credit          [CHANNELS];

    logic [CHANNELS-1:0][PORTS-1:0]     port_request;
    logic [CHANNELS-1:0][PORTS-1:0]     port_grant;
    logic [CHANNELS-1:0]                port_advance;
    logic [CHANNELS-1:0][PIW-1:0]       cand_port;
    logic [CHANNELS-1:0]                vc_request;
    logic [CHANNELS-1:0]                vc_grant;
    logic                               accept;
    logic                               sel_last;
    logic [FLIT_WIDTH-1:0]              sel_flit;

    // Regroup the flat request vector per VC for the port arbiters.
    always_comb begin
        port_request = '0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                port_request[v][p] = i_valid[p*CHANNELS+v];
            end
        end
    end

    for (genvar v = 0; v < CHANNELS; v++) begin : g_port_arb
        tnoc_round_robin_arbiter #(
            .REQUESTS (PORTS)
        ) u_port_arbiter (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_request (port_request[v]),
            .i_advance (port_advance[v]),
            .o_grant   (port_grant[v])
        );
    end

    // Candidate port per VC (lock owner or arbiter winner) and VC eligibility.
    always_comb begin
        cand_port  = '0;
        vc_request = '0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            if (lock_state[v] == LOCKED) begin
                cand_port[v] = lock_owner[v];
            end else begin
                for (int unsigned p = 0; p < PORTS; p++) begin
                    if (port_grant[v][p]) begin
                        cand_port[v] = PIW'(p);
                    end
                end
            end
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (cand_port[v] == PIW'(p)) begin
                    vc_request[v] = i_valid[p*CHANNELS+v] && (credit[v] != '0);
                end
            end
        end
    end

`ifdef TNOC_VC_FIXED_PRIORITY_EN
    // Fixed-priority VC select: lowest eligible index wins.
    always_comb begin
        vc_grant = '0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            if (vc_request[v] && (vc_grant == '0)) begin
                vc_grant[v] = 1'b1;
            end
        end
    end
`else
    tnoc_round_robin_arbiter #(
        .REQUESTS (CHANNELS)
    ) u_vc_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_request (vc_request),
        .i_advance (accept),
        .o_grant   (vc_grant)
    );
`endif

    // Decode the single accepted (port, VC) pair and mux its flit.
    always_comb begin
        accept       = |vc_grant;
        o_ready      = '0;
        sel_last     = 1'b0;
        sel_flit     = '0;
        port_advance = '0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            port_advance[v] = vc_grant[v] && (lock_state[v] == IDLE);
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (vc_grant[v] && (cand_port[v] == PIW'(p))) begin
                    o_ready[p*CHANNELS+v] = 1'b1;
                    sel_last              = i_last[p*CHANNELS+v];
                    sel_flit              = i_flit[(p*CHANNELS+v)*FLIT_WIDTH +: FLIT_WIDTH];
                end
            end
        end
    end

    // Lock state register per VC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < CHANNELS; v++) begin
                lock_state[v] <= IDLE;
                lock_owner[v] <= '0;
            end
        end else begin
            for (int unsigned v = 0; v < CHANNELS; v++) begin
                lock_state[v] <= lock_state_next[v];
                lock_owner[v] <= lock_owner_next[v];
            end
        end
    end

    // Lock next state: a multi-flit head locks the VC, its tail releases it.
    always_comb begin
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            lock_state_next[v] = lock_state[v];
            lock_owner_next[v] = lock_owner[v];
            if (vc_grant[v]) begin
                case (lock_state[v])
                    IDLE: begin
                        if (!sel_last) begin
                            lock_state_next[v] = LOCKED;
                            lock_owner_next[v] = cand_port[v];
                        end
                    end
                    LOCKED: begin
                        if (sel_last) begin
                            lock_state_next[v] = IDLE;
                        end
                    end
                    default: lock_state_next[v] = IDLE;
                endcase
            end
        end
    end

    // Credit counters: spend on accept, refill on return, saturate at CREDITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < CHANNELS; v++) begin
                credit[v] <= CW'(CREDITS);
            end
        end else begin
            for (int unsigned v = 0; v < CHANNELS; v++) begin
                case ({vc_grant[v], i_credit_return[v]})
                    2'b10:   credit[v] <= credit[v] - 1'b1;
                    2'b01: begin
                        if (credit[v] != CW'(CREDITS)) begin
                            credit[v] <= credit[v] + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A return with a full counter means downstream freed a slot it never held.
    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            if (rst_n && i_credit_return[v] && !vc_grant[v]) begin
                assert (credit[v] != CW'(CREDITS));
            end
        end
    end

    // Expose credit counters for debug.
    always_comb begin
        o_credit_count = '0;
        for (int unsigned v = 0; v < CHANNELS; v++) begin
            o_credit_count[v*CW +: CW] = credit[v];
        end
    end

    // Output register: one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_vc    <= '0;
            o_last  <= 1'b0;
            o_flit  <= '0;
        end else begin
            o_valid <= accept;
            o_vc    <= vc_grant;
            o_last  <= accept && sel_last;
            if (accept) begin
                o_flit <= sel_flit;
            end
        end
    end

endmodule

// File: tb/tb_tnoc_vc_output_switch.sv
// Self-checking bench for tnoc_vc_output_switch: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_tnoc_vc_output_switch;

    localparam int P  = 5;
    localparam int C  = 2;
    localparam int FW = 64;
    localparam int CR = 4;
    localparam int CW = $clog2(CR + 1);
    localparam int S  = P * C;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [S-1:0]    i_valid;
    logic [S-1:0]    i_last;
    logic [S*FW-1:0] i_flit;
    logic [S-1:0]    o_ready;
    logic            o_valid;
    logic [C-1:0]    o_vc;
    logic            o_last;
    logic [FW-1:0]   o_flit;
    logic [C-1:0]    i_credit_return;
    logic [C*CW-1:0] o_credit_count;

    logic [FW-1:0]   flit_r [S];

    always #5 clk = ~clk;

    always_comb begin
        for (int s = 0; s < S; s++) i_flit[s*FW +: FW] = flit_r[s];
    end

    tnoc_vc_output_switch #(
        .PORTS      (P),
        .CHANNELS   (C),
        .FLIT_WIDTH (FW),
        .CREDITS    (CR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .i_last          (i_last),
        .i_flit          (i_flit),
        .o_ready         (o_ready),
        .o_valid         (o_valid),
        .o_vc            (o_vc),
        .o_last          (o_last),
        .o_flit          (o_flit),
        .i_credit_return (i_credit_return),
        .o_credit_count  (o_credit_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Source queues per (port, VC) slot: bit FW = tail marker.
    logic [FW:0] q [S][$];
    int          present_pct = 100;
    int          ret_pct     = 0;
    logic [C-1:0] man_ret    = '0;
    int          seq         = 0;

    // Behavioural model state.
    int          m_cred   [C];
    bit          m_locked [C];
    int          m_owner  [C];
    int          m_pptr   [C];
    int          m_vptr;
    int          acc_slot = -1;
    bit          exp_valid;
    logic [C-1:0] exp_vc;
    bit          exp_last;
    logic [FW-1:0] exp_flit;
    logic [FW+C-1:0] log_q [$];

    int          cand [C];
    bit          elig [C];
    int          sel_v;
    logic [S-1:0] exp_ready;

    // Compare process: DUT vs model every cycle, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int v = 0; v < C; v++) begin
                m_cred[v] = CR; m_locked[v] = 0; m_owner[v] = 0; m_pptr[v] = 0;
            end
            m_vptr = 0; acc_slot = -1; exp_valid = 0; exp_vc = '0; exp_last = 0; exp_flit = '0;
        end else begin
            for (int v = 0; v < C; v++) begin
                cand[v] = -1;
                if (m_locked[v]) cand[v] = m_owner[v];
                else begin
                    for (int k = 0; k < P; k++) begin
                        int p;
                        p = (m_pptr[v] + k) % P;
                        if (cand[v] < 0 && i_valid[p*C+v]) cand[v] = p;
                    end
                end
                elig[v] = (cand[v] >= 0) && i_valid[cand[v]*C+v] && (m_cred[v] > 0);
            end
            sel_v = -1;
`ifdef TNOC_VC_FIXED_PRIORITY_EN
            for (int v = 0; v < C; v++) if (sel_v < 0 && elig[v]) sel_v = v;
`else
            for (int k = 0; k < C; k++) begin
                int v;
                v = (m_vptr + k) % C;
                if (sel_v < 0 && elig[v]) sel_v = v;
            end
`endif
            exp_ready = '0;
            if (sel_v >= 0) exp_ready = S'(1) << (cand[sel_v]*C + sel_v);

            chk("o_ready", 64'(o_ready), 64'(exp_ready));
            chk("o_valid", 64'(o_valid), 64'(exp_valid));
            if (exp_valid) begin
                chk("o_vc", 64'(o_vc), 64'(exp_vc));
                chk("o_last", 64'(o_last), 64'(exp_last));
                chk("o_flit", o_flit, exp_flit);
            end
            for (int v = 0; v < C; v++)
                chk("credit", 64'(o_credit_count[v*CW +: CW]), 64'(m_cred[v]));
            if (o_valid) log_q.push_back({o_vc, o_flit});

            acc_slot = -1; exp_valid = 0; exp_vc = '0; exp_last = 0;
            if (sel_v >= 0) begin
                int s;
                s = cand[sel_v]*C + sel_v;
                acc_slot  = s;
                exp_valid = 1;
                exp_vc    = C'(1) << sel_v;
                exp_last  = i_last[s];
                exp_flit  = flit_r[s];
                m_cred[sel_v]--;
                if (!m_locked[sel_v]) begin
                    m_pptr[sel_v] = (cand[sel_v] + 1) % P;
                    if (!i_last[s]) begin m_locked[sel_v] = 1; m_owner[sel_v] = cand[sel_v]; end
                end else if (i_last[s]) m_locked[sel_v] = 0;
                m_vptr = (sel_v + 1) % C;
            end
            for (int v = 0; v < C; v++)
                if (i_credit_return[v] && m_cred[v] < CR) m_cred[v]++;
        end
    end

    task automatic push_pkt(input int p, input int v, input int len, input bit tail);
        for (int i = 0; i < len; i++) begin
            logic [FW-1:0] d;
            d = {8'(p), 8'(v), 16'(seq), $urandom()};
            seq++;
            q[p*C+v].push_back({(tail && (i == len - 1)), d});
        end
    endtask

    // One clock: retire accepted flits, present new ones, drive credit returns.
    task automatic step();
        @(posedge clk); #1;
        for (int s = 0; s < S; s++) begin
            if (i_valid[s] && acc_slot == s) begin
                void'(q[s].pop_front());
                i_valid[s] = 1'b0;
            end
            if (!i_valid[s] && q[s].size() > 0 && rst_n && ($urandom_range(99) < present_pct)) begin
                logic [FW:0] head;
                head = q[s][0];
                i_valid[s] = 1'b1;
                i_last[s]  = head[FW];
                flit_r[s]  = head[FW-1:0];
            end
        end
        for (int v = 0; v < C; v++)
            i_credit_return[v] = man_ret[v] || (rst_n && m_cred[v] < CR && ($urandom_range(99) < ret_pct));
    endtask

    function automatic bit busy();
        bit b;
        b = (i_valid != '0);
        for (int s = 0; s < S; s++) if (q[s].size() > 0) b = 1;
        return b;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy() && n < 2000) begin step(); n++; end
        chk("drain_timeout", 64'(busy()), 64'(0));
        step(); step();
    endtask

    task automatic fill_credits();
        int n;
        bit low;
        ret_pct = 100;
        n = 0;
        low = 1;
        while (low && n < 100) begin
            step(); n++;
            low = 0;
            for (int v = 0; v < C; v++) if (m_cred[v] < CR) low = 1;
        end
        for (int v = 0; v < C; v++) chk("fill_credit", 64'(o_credit_count[v*CW +: CW]), 64'(CR));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int alt, v0first;
        logic [FW+C-1:0] e, e2;
        i_valid = '0; i_last = '0; i_credit_return = '0;
        for (int s = 0; s < S; s++) flit_r[s] = '0;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_vc", 64'(o_vc), 64'(0));
        chk("rst_flit", o_flit, 64'(0));
        chk("rst_credit0", 64'(o_credit_count[0 +: CW]), 64'(4));
        chk("rst_credit1", 64'(o_credit_count[CW +: CW]), 64'(4));
        rst_n = 1'b1;

        // Single flit, port1 / VC0.
        push_pkt(1, 0, 1, 1);
        step(); step();
        chk("t1_valid", 64'(o_valid), 64'(1));
        chk("t1_vc", 64'(o_vc), 64'(2'b01));
        chk("t1_port", 64'(o_flit[FW-1 -: 8]), 64'(1));
        chk("t1_last", 64'(o_last), 64'(1));
        chk("t1_credit0", 64'(o_credit_count[0 +: CW]), 64'(3));
        wait_idle();

        // Wormhole lock: port2 waits behind port0's 3-flit packet.
        ret_pct = 100;
        log_q.delete();
        push_pkt(0, 0, 3, 1);
        step();
        push_pkt(2, 0, 1, 1);
        wait_idle();
        chk("t2_count", 64'(log_q.size()), 64'(4));
        if (log_q.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                e = log_q[i];
                chk("t2_order_p0", 64'(e[FW-1 -: 8]), 64'(0));
            end
            e = log_q[3];
            chk("t2_order_p2", 64'(e[FW-1 -: 8]), 64'(2));
        end

        // Credit exhaustion on VC1.
        fill_credits();
        ret_pct = 0;
        log_q.delete();
        push_pkt(3, 1, 6, 1);
        repeat (8) step();
        chk("t3_passed", 64'(log_q.size()), 64'(4));
        chk("t3_credit1", 64'(o_credit_count[CW +: CW]), 64'(0));
        chk("t3_stalled", 64'(o_ready[3*C+1]), 64'(0));
        man_ret = 2'b10;
        step();
        man_ret = '0;
        step();
        chk("t3_credit_back", 64'(o_credit_count[CW +: CW]), 64'(1));
        step();
        chk("t3_fifth_valid", 64'(o_valid), 64'(1));
        chk("t3_fifth_vc", 64'(o_vc), 64'(2'b10));
        ret_pct = 100;
        wait_idle();

        // VC interleave.
        fill_credits();
        log_q.delete();
        push_pkt(0, 0, 4, 1);
        push_pkt(1, 1, 4, 1);
        wait_idle();
        chk("t4_count", 64'(log_q.size()), 64'(8));
        if (log_q.size() == 8) begin
            alt = 0; v0first = 0;
            for (int i = 0; i < 7; i++) begin
                e = log_q[i]; e2 = log_q[i+1];
                if (e[FW +: C] != e2[FW +: C]) alt++;
            end
            for (int i = 0; i < 4; i++) begin
                e = log_q[i];
                if (e[FW +: C] == 2'b01) v0first++;
            end
`ifdef TNOC_VC_FIXED_PRIORITY_EN
            chk("t4_vc0_first", 64'(v0first), 64'(4));
`else
            chk("t4_alternate", 64'(alt), 64'(7));
`endif
        end

        // Simultaneous accept and return at count 2.
        fill_credits();
        ret_pct = 0;
        push_pkt(4, 0, 1, 1);
        push_pkt(4, 0, 1, 1);
        wait_idle();
        chk("t5_credit_before", 64'(o_credit_count[0 +: CW]), 64'(2));
        push_pkt(4, 0, 1, 1);
        man_ret = 2'b01;
        step();
        man_ret = '0;
        step();
        chk("t5_credit_same", 64'(o_credit_count[0 +: CW]), 64'(2));
        chk("t5_valid", 64'(o_valid), 64'(1));
        wait_idle();

        // Reset mid-packet with the lock held and one credit left.
        fill_credits();
        ret_pct = 0;
        push_pkt(0, 0, 3, 0);
        wait_idle();
        chk("t6_credit_low", 64'(o_credit_count[0 +: CW]), 64'(1));
        push_pkt(0, 0, 1, 1);
        step();
        #2;
        rst_n = 1'b0;
        i_valid = '0;
        for (int s = 0; s < S; s++) q[s].delete();
        #1;
        chk("t6_rst_valid", 64'(o_valid), 64'(0));
        chk("t6_rst_vc", 64'(o_vc), 64'(0));
        chk("t6_rst_last", 64'(o_last), 64'(0));
        chk("t6_rst_flit", o_flit, 64'(0));
        chk("t6_rst_credit0", 64'(o_credit_count[0 +: CW]), 64'(4));
        step(); step();
        rst_n = 1'b1;
        chk("t6_credit_after", 64'(o_credit_count[0 +: CW]), 64'(4));
        push_pkt(3, 0, 1, 1);
        step(); step();
        chk("t6_new_valid", 64'(o_valid), 64'(1));
        chk("t6_new_port", 64'(o_flit[FW-1 -: 8]), 64'(3));
        chk("t6_new_vc", 64'(o_vc), 64'(2'b01));
        wait_idle();

        // Randomized traffic.
        ret_pct = 40;
        present_pct = 70;
        for (int n = 0; n < 3000; n++) begin
            for (int s = 0; s < S; s++)
                if (q[s].size() < 6 && $urandom_range(99) < 3)
                    push_pkt(s / C, s % C, $urandom_range(1, 4), 1);
            step();
        end
        present_pct = 100;
        ret_pct = 100;
        wait_idle();
        fill_credits();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
